pc_fetch_sequencer: RTL and testbench
=====================================

Name: pc_fetch_sequencer

Overview:
Owns the program counter register and sequences instruction fetch. Each cycle it selects the next PC from: sequential PC+PC_STEP, branch target, or jump target. It drives a req/ready handshake to instruction memory and absorbs stalls. It also discards responses for fetches squashed by a redirect. It sits between the decode/branch unit and instruction memory, and replaces the bare PC+4 adder path.

Parameters:
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
PC_STEP, 32'd4, sequential increment per accepted fetch.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
stall  input  1  downstream cannot accept a new instruction.
branch_taken  input  1  conditional redirect request, level, sampled every cycle.
branch_target  input  32  branch destination.
jump  input  1  unconditional redirect request; has priority over branch_taken.
jump_target  input  32  jump destination.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  32  fetch address; stable while imem_req=1 and imem_ready=0.
imem_ready  input  1  memory accepts/completes the request this cycle (valid only when imem_req=1).
fetch_valid  output  1  one-cycle pulse: a non-squashed fetch completed.
fetch_pc  output  32  address of the completed fetch; qualified by fetch_valid.
pc  output  32  current PC register.
align_err  output  1  sticky: a redirect target had bits[1:0]!=0.

Behaviour:
- Reset (clk edge with reset=1): pc=RESET_VECTOR, state=BOOT, imem_req=0, imem_addr=RESET_VECTOR, fetch_valid=0, fetch_pc=0, align_err=0, pending target=0. Reset overrides every state, including DRAIN mid-transaction.
- Redirect select: jump ? jump_target : branch_taken ? branch_target : none.
- Misaligned selected target → ERROR on next edge, align_err=1.
- States: BOOT, FETCH, STALL, DRAIN, ERROR.
- BOOT: imem_req=0; next state FETCH unconditionally. Redirects are ignored.
- FETCH: imem_req=1, imem_addr=pc.
  - ready & no redirect: next cycle fetch_valid=1, fetch_pc=pc; pc←pc+PC_STEP (mod 2^32, 32'hFFFF_FFFC wraps to 0, no error). Next state is STALL if stall, else FETCH.
  - ready & redirect: response squashed (fetch_valid=0); pc←target. Next state is STALL if stall, else FETCH.
  - !ready & redirect: pending←target, go to DRAIN. imem_addr is held at the old pc (a request cannot be retracted).
  - !ready & no redirect: hold; stall does not drop an outstanding request.
- STALL: imem_req=0. A redirect updates pc←target and stays in STALL. When stall=0, go to FETCH the next cycle.
- DRAIN: imem_req=1, imem_addr=old pc.
  - A new redirect overwrites pending (latest wins; jump beats branch in the same cycle).
  - On imem_ready: the response is dropped, pc←pending (or the same-cycle redirect target). Next state is STALL if stall, else FETCH.
- ERROR: imem_req=0, fetch_valid=0, pc frozen. Exit only via reset.
- fetch_valid is registered: at most 1 pulse per imem_ready, latency 1 cycle after the ready edge.
- All outputs are registered or decoded from the state/pc registers; there is no combinational path from inputs to imem_req/imem_addr.

Test Plan:
- Reset, then imem_ready tied 1 → BOOT 1 cycle. imem_addr sequence is 0,4,8,12. fetch_valid pulses with fetch_pc 0,4,8 one cycle after each accept.
- imem_ready=0 for 3 cycles at pc=8 → imem_addr holds 8, imem_req stays 1, no fetch_valid. On ready, fetch_pc=8 and next addr=12.
- jump=1, jump_target=0x100 and branch_taken=1, branch_target=0x200 together while ready=1 → response squashed, next imem_addr=0x100.
- branch_taken to 0x40 while waiting (ready=0), then a jump to 0x80 before ready → DRAIN holds the old addr; after ready, the fetch is dropped and next addr=0x80.
- stall=1 at accept → fetch_valid pulses once, imem_req=0 during stall. A branch to 0x20 during stall leaves pc=0x20. Stall release → imem_addr=0x20.
- Set RESET_VECTOR=32'hFFFF_FFF8 with ready=1 → addr sequence is ...F8, ...FC, 0x0. A branch to 0x6 → align_err=1, imem_req=0 until reset. Reset asserted mid-DRAIN → pc=RESET_VECTOR, state BOOT.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and instruction-fetch sequencer: picks sequential, branch or
// jump PC, handshakes with instruction memory and drops responses squashed by redirects.
module pc_fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_pc,
  output logic [31:0] pc,
  output logic        align_err
);

  typedef enum logic [2:0] {BOOT, FETCH, STALL, DRAIN, ERROR} state_t;

  state_t      state, state_nxt;
  logic [31:0] pending, pending_nxt;
  logic [31:0] pc_nxt, fetch_pc_nxt;
  logic        fetch_valid_nxt, align_err_nxt;
  logic        redir, misalign;
  logic [31:0] target;

  assign redir    = jump | branch_taken;
  assign target   = jump ? jump_target : branch_target;
  assign misalign = redir & (target[1:0] != 2'b00);

  // The address is the PC register itself; in DRAIN the PC is not updated until the
  // outstanding request completes, so the old address is held naturally.
  assign imem_req  = (state == FETCH) || (state == DRAIN);
  assign imem_addr = pc;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pending_nxt     = pending;
    fetch_valid_nxt = 1'b0;
    fetch_pc_nxt    = fetch_pc;
    align_err_nxt   = align_err;
    case (state)
      BOOT: state_nxt = FETCH;
      FETCH: begin
        if (misalign) begin
          state_nxt     = ERROR;
          align_err_nxt = 1'b1;
        end else if (imem_ready) begin
          if (redir) begin
            pc_nxt = target;
          end else begin
            fetch_valid_nxt = 1'b1;
            fetch_pc_nxt    = pc;
            pc_nxt          = pc + PC_STEP;
          end
          state_nxt = stall ? STALL : FETCH;
        end else if (redir) begin
          pending_nxt = target;
          state_nxt   = DRAIN;
        end
      end
      STALL: begin
        if (misalign) begin
          state_nxt     = ERROR;
          align_err_nxt = 1'b1;
        end else begin
          if (redir) pc_nxt = target;
          if (!stall) state_nxt = FETCH;
        end
      end
      DRAIN: begin
        if (misalign) begin
          state_nxt     = ERROR;
          align_err_nxt = 1'b1;
        end else begin
          if (redir) pending_nxt = target;
          // Response belongs to the squashed address and is discarded.
          if (imem_ready) begin
            pc_nxt    = redir ? target : pending;
            state_nxt = stall ? STALL : FETCH;
          end
        end
      end
      ERROR: state_nxt = ERROR;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_VECTOR;
      pending     <= 32'd0;
      fetch_valid <= 1'b0;
      fetch_pc    <= 32'd0;
      align_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pending     <= pending_nxt;
      fetch_valid <= fetch_valid_nxt;
      fetch_pc    <= fetch_pc_nxt;
      align_err   <= align_err_nxt;
    end
  end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Randomized bench for pc_fetch_sequencer against a flag-based behavioural model of the
// fetch rules, with directed openers for boot, wrap-around, drain and reset.
module tb_pc_fetch_sequencer;

  localparam logic [31:0] RV   = 32'hFFFF_FFF8;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken, jump, imem_ready;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, fetch_valid, align_err;
  logic [31:0] imem_addr, fetch_pc, pc;

  int n_checks = 0;
  int n_fail   = 0;

  pc_fetch_sequencer #(.RESET_VECTOR(RV), .PC_STEP(STEP)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .pc(pc), .align_err(align_err)
  );

  always #5 clk = ~clk;

  // Reference model: a handful of independent facts about the sequencer.
  logic [31:0] m_pc, m_saved, m_fpc;
  bit          m_booting, m_resting, m_squash, m_dead, m_err, m_fv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit          want;
    logic [31:0] dest;
    want = jump | branch_taken;
    dest = jump ? jump_target : branch_target;
    m_fv = 1'b0;
    if (reset) begin
      m_pc = RV; m_saved = '0; m_fpc = '0;
      m_booting = 1; m_resting = 0; m_squash = 0; m_dead = 0; m_err = 0;
    end else if (m_dead) begin
      // frozen
    end else if (m_booting) begin
      m_booting = 0;
    end else if (want && dest[1:0] != 2'b00) begin
      m_dead = 1; m_err = 1;
    end else if (m_resting) begin
      if (want) m_pc = dest;
      if (!stall) m_resting = 0;
    end else if (m_squash) begin
      if (want) m_saved = dest;
      if (imem_ready) begin
        m_pc = m_saved; m_squash = 0; m_resting = stall;
      end
    end else if (imem_ready) begin
      if (want) m_pc = dest;
      else begin m_fv = 1; m_fpc = m_pc; m_pc = m_pc + STEP; end
      m_resting = stall;
    end else if (want) begin
      m_saved = dest; m_squash = 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check("imem_req", {31'd0, imem_req}, {31'd0, !m_dead && !m_booting && !m_resting});
    check("pc", pc, m_pc);
    check("imem_addr", imem_addr, m_pc);
    check("fetch_valid", {31'd0, fetch_valid}, {31'd0, m_fv});
    if (m_fv) check("fetch_pc", fetch_pc, m_fpc);
    check("align_err", {31'd0, align_err}, {31'd0, m_err});
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; branch_taken = 0; jump = 0; imem_ready = 1;
    branch_target = '0; jump_target = '0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_pc = '0; m_saved = '0; m_fpc = '0;
    m_booting = 0; m_resting = 0; m_squash = 0; m_dead = 0; m_err = 0; m_fv = 0;
    repeat (2) cycle();
    reset = 0;
    // Boot, then sequential fetch across the 32-bit wrap.
    repeat (6) cycle();
    // Memory wait, then a redirect while waiting and a later jump before ready.
    imem_ready = 0;
    repeat (2) cycle();
    branch_taken = 1; branch_target = 32'h40;
    cycle();
    branch_taken = 0; jump = 1; jump_target = 32'h80;
    cycle();
    jump = 0;
    cycle();
    imem_ready = 1;
    repeat (3) cycle();
    // Reset asserted in the middle of a drain.
    imem_ready = 0; jump = 1; jump_target = 32'h100;
    cycle();
    jump = 0;
    cycle();
    reset = 1;
    cycle();
    idle_inputs();
    repeat (3) cycle();
    // Stall with a branch during the stall.
    stall = 1;
    repeat (2) cycle();
    branch_taken = 1; branch_target = 32'h20;
    cycle();
    branch_taken = 0; stall = 0;
    repeat (3) cycle();
    // Misaligned branch target.
    branch_taken = 1; branch_target = 32'h6;
    cycle();
    branch_taken = 0;
    repeat (3) cycle();
    reset = 1;
    cycle();
    reset = 0;

    for (int i = 0; i < 4000; i++) begin
      reset        = m_dead ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 199) == 0);
      stall        = ($urandom_range(0, 3) == 0);
      imem_ready   = ($urandom_range(0, 2) != 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      jump         = ($urandom_range(0, 9) == 0);
      branch_target = $urandom() & 32'hFFFF_FFFC;
      jump_target   = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(0, 59) == 0) branch_target[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 59) == 0) jump_target[1:0]   = 2'($urandom_range(1, 3));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
